narrow_port_isolate_ctrl: RTL and testbench
===========================================

Name: narrow_port_isolate_ctrl

Overview:
- Per-port isolation controller placed in front of one cluster-side narrow AXI port (soc_clk_i domain, either direction of the narrow data-width adapter).
- Tracks outstanding write and read transactions and stops new AW/AR on request.
- Reports "isolated" once the port is fully drained, so the cluster can be clock-gated, reset or reconfigured safely.
- Also throttles a port to a maximum number of outstanding transactions per direction.

Parameters:
- MaxTxns, 8, maximum outstanding transactions per direction (write, read); range 1..255.
- req_t, logic, AXI request struct (aw/w/ar channels, valids, b_ready, r_ready).
- resp_t, logic, AXI response struct (readies, b/r channels, valids).
- CntW, $clog2(MaxTxns+1), derived counter width; not to be overridden.

Ports:
- soc_clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- isolate_req_i  in  1  level request to isolate the port.
- isolated_o  out  1  port drained and blocked.
- slv_req_i  in  $bits(req_t)  request from upstream master.
- slv_resp_o  out  $bits(resp_t)  response to upstream master.
- mst_req_o  out  $bits(req_t)  request to downstream adapter/cluster.
- mst_resp_i  in  $bits(resp_t)  response from downstream.
- outstanding_wr_o  out  CntW  outstanding write count.
- outstanding_rd_o  out  CntW  outstanding read count.
- err_o  out  1  sticky protocol error (response with zero outstanding).

Behaviour:
- Events:
  - aw_fire = mst_req_o.aw_valid & mst_resp_i.aw_ready.
  - b_fire = mst_resp_i.b_valid & slv_req_i.b_ready.
  - ar_fire = AR handshake.
  - rl_fire = R handshake with r.last.
- Counters:
  - wr_cnt += aw_fire, -= b_fire; rd_cnt += ar_fire, -= rl_fire.
  - Simultaneous increment and decrement leaves the count unchanged.
  - A decrement at 0 holds the counter at 0 and sets err_o; err_o clears only on reset.
- Pending flags:
  - aw_pend is set when mst aw_valid & !aw_ready, and cleared on aw_fire; ar_pend likewise.
  - These flags keep AXI valid stability: a valid already presented downstream is never withdrawn.
- Gating (combinational, zero latency):
  - blk_aw = !aw_pend & (state!=ACTIVE | wr_cnt==MaxTxns).
  - When blk_aw: mst aw_valid=0 and slv aw_ready=0. AR is gated the same way with blk_ar / rd_cnt.
  - W is gated (w_valid=0, w_ready=0) only in ISOLATED.
  - B and R always pass through; every other field passes unmodified.
- FSM states ACTIVE, DRAIN, ISOLATED:
  - ACTIVE -> DRAIN when isolate_req_i=1.
  - DRAIN -> ISOLATED when wr_cnt==0 & rd_cnt==0 & !aw_pend & !ar_pend. If this already holds at entry, ISOLATED follows one cycle after DRAIN, so isolated_o rises 2 cycles after the request at minimum.
  - DRAIN -> ACTIVE if isolate_req_i drops before drained.
  - ISOLATED -> ACTIVE when isolate_req_i=0; isolated_o falls the next cycle.
- isolated_o is registered: isolated_o = (state==ISOLATED).
- Reset values:
  - state=ACTIVE; counters=0; pend flags=0; isolated_o=0; err_o=0.
  - Outputs pass through with gating evaluated on reset state.
- Reset mid-transaction clears all tracking. Downstream must be reset together; this is a system-level requirement and is not checked.
- Saturation: at wr_cnt==MaxTxns a new AW stalls until a B retires. B and AW in the same cycle at the maximum: the AW is blocked that cycle (gating uses the registered count).

Decomposition:
- Package narrow_isolate_pkg: state enum isolate_state_e (ACTIVE, DRAIN, ISOLATED) and the default MaxTxns constant.
- Sub-module narrow_txn_counter, instantiated twice (write, read):
  - Parameters: MaxTxns.
  - Inputs: inc_i, dec_i.
  - Outputs: cnt_o, full_o, empty_o, underflow_o.
  - Async active-high reset.

Test Plan:
- Idle isolate: no traffic, raise isolate_req_i at cycle 0 -> isolated_o=1 at cycle 2, an AW presented afterwards sees aw_ready=0 and mst aw_valid=0.
- Drain writes: issue 3 AWs (with W), raise isolate while no B has returned -> state DRAIN, wr_cnt=3. Return 3 Bs one per cycle -> isolated_o asserts 2 cycles after the third B.
- Valid stability: AW valid held downstream with aw_ready=0, isolate raised -> mst aw_valid stays 1 until accepted, wr_cnt becomes 1, isolated_o only after the matching B.
- Saturation with MaxTxns=2: issue 3 ARs -> the third is stalled (ar_ready=0). The first R with last=1 frees a slot -> the third AR is accepted the next cycle, rd_cnt stays at 2.
- Abort and release: isolate asserted in DRAIN then dropped with rd_cnt=1 -> state ACTIVE next cycle, new AR passes. Isolate dropped in ISOLATED -> isolated_o=0 one cycle later.
- Error and reset: inject a B with wr_cnt=0 -> err_o=1 sticky, counter stays 0. Assert rst_i mid-DRAIN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/narrow_isolate_pkg.sv
// Shared types for the narrow-port isolation controller: FSM states, default
// outstanding limit and a compact narrow AXI request/response pair.
package narrow_isolate_pkg;

    localparam int unsigned DefaultMaxTxns = 8;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } isolate_state_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
    } narrow_ax_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic        last;
    } narrow_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } narrow_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] data;
        logic [1:0]  resp;
        logic        last;
    } narrow_r_t;

    typedef struct packed {
        narrow_ax_t aw;
        logic       aw_valid;
        narrow_w_t  w;
        logic       w_valid;
        logic       b_ready;
        narrow_ax_t ar;
        logic       ar_valid;
        logic       r_ready;
    } narrow_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      ar_ready;
        logic      w_ready;
        narrow_b_t b;
        logic      b_valid;
        narrow_r_t r;
        logic      r_valid;
    } narrow_resp_t;

endpackage

// File: rtl/narrow_txn_counter.sv
// Outstanding-transaction counter for one direction; saturates at MaxTxns,
// holds at zero and flags an underflow when a response arrives with nothing open.
module narrow_txn_counter
    import narrow_isolate_pkg::*;
#(
    parameter int unsigned MaxTxns = DefaultMaxTxns,
    localparam int unsigned CntW   = $clog2(MaxTxns + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            underflow_o
);

    logic [CntW-1:0] cnt_q;

    assign cnt_o       = cnt_q;
    assign full_o      = (cnt_q == CntW'(MaxTxns));
    assign empty_o     = (cnt_q == '0);
    // A simultaneous inc cancels the dec, so it is not counted as an underflow.
    assign underflow_o = dec_i & ~inc_i & empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_q <= cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/narrow_port_isolate_ctrl.sv
// Isolation/throttle controller in front of one cluster-side narrow AXI port:
// blocks new AW/AR on request, drains outstanding traffic, then reports isolated.
module narrow_port_isolate_ctrl
    import narrow_isolate_pkg::*;
#(
    parameter int unsigned MaxTxns = DefaultMaxTxns,
    parameter type         req_t   = narrow_req_t,
    parameter type         resp_t  = narrow_resp_t,
    parameter int unsigned CntW    = $clog2(MaxTxns + 1)
) (
    input  logic            soc_clk_i,
    input  logic            rst_i,
    input  logic            isolate_req_i,
    output logic            isolated_o,
    input  req_t            slv_req_i,
    output resp_t           slv_resp_o,
    output req_t            mst_req_o,
    input  resp_t           mst_resp_i,
    output logic [CntW-1:0] outstanding_wr_o,
    output logic [CntW-1:0] outstanding_rd_o,
    output logic            err_o
);

    isolate_state_e state_q, state_d;
    logic aw_pend_q, ar_pend_q;
    logic err_q;
    logic blk_aw, blk_ar, blk_w;
    logic aw_fire, b_fire, ar_fire, rl_fire;
    logic wr_full, wr_empty, wr_uf;
    logic rd_full, rd_empty, rd_uf;
    logic drained;

    // Gating looks only at registered state, so a retiring B cannot open a slot
    // for an AW in the same cycle; a pending valid is never withdrawn.
    assign blk_aw = ~aw_pend_q & ((state_q != ACTIVE) | wr_full);
    assign blk_ar = ~ar_pend_q & ((state_q != ACTIVE) | rd_full);
    assign blk_w  = (state_q == ISOLATED);

    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;
        if (blk_aw) begin
            mst_req_o.aw_valid  = 1'b0;
            slv_resp_o.aw_ready = 1'b0;
        end
        if (blk_ar) begin
            mst_req_o.ar_valid  = 1'b0;
            slv_resp_o.ar_ready = 1'b0;
        end
        if (blk_w) begin
            mst_req_o.w_valid  = 1'b0;
            slv_resp_o.w_ready = 1'b0;
        end
    end

    assign aw_fire = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_fire = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign b_fire  = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign rl_fire = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    narrow_txn_counter #(.MaxTxns(MaxTxns)) i_wr_cnt (
        .clk_i       (soc_clk_i),
        .rst_i       (rst_i),
        .inc_i       (aw_fire),
        .dec_i       (b_fire),
        .cnt_o       (outstanding_wr_o),
        .full_o      (wr_full),
        .empty_o     (wr_empty),
        .underflow_o (wr_uf)
    );

    narrow_txn_counter #(.MaxTxns(MaxTxns)) i_rd_cnt (
        .clk_i       (soc_clk_i),
        .rst_i       (rst_i),
        .inc_i       (ar_fire),
        .dec_i       (rl_fire),
        .cnt_o       (outstanding_rd_o),
        .full_o      (rd_full),
        .empty_o     (rd_empty),
        .underflow_o (rd_uf)
    );

    assign drained = wr_empty & rd_empty & ~aw_pend_q & ~ar_pend_q;

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ACTIVE;
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_fire)                    aw_pend_q <= 1'b0;
            else if (mst_req_o.aw_valid)    aw_pend_q <= 1'b1;
            if (ar_fire)                    ar_pend_q <= 1'b0;
            else if (mst_req_o.ar_valid)    ar_pend_q <= 1'b1;
            err_q <= err_q | wr_uf | rd_uf;
        end
    end

    // A withdrawn request wins over a coincident drain so the port is not
    // isolated after nobody asks for it any more.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:   if (isolate_req_i) state_d = DRAIN;
            DRAIN: begin
                if (!isolate_req_i)  state_d = ACTIVE;
                else if (drained)    state_d = ISOLATED;
            end
            ISOLATED: if (!isolate_req_i) state_d = ACTIVE;
            default:  state_d = ACTIVE;
        endcase
    end

    assign isolated_o = (state_q == ISOLATED);
    assign err_o      = err_q;

endmodule

// File: tb/tb_narrow_port_isolate_ctrl.sv
// Directed bench for narrow_port_isolate_ctrl (MaxTxns=3): a cycle table of
// write/read traffic plus hand sequences for isolate, valid stability, error, reset.
module tb_narrow_port_isolate_ctrl;
    import narrow_isolate_pkg::*;

    localparam int unsigned MAXT = 3;
    localparam int unsigned CW   = $clog2(MAXT + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         iso_req;
    logic         iso;
    narrow_req_t  slv_req, mst_req;
    narrow_resp_t slv_resp, mst_resp;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic         err;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    narrow_port_isolate_ctrl #(.MaxTxns(MAXT)) dut (
        .soc_clk_i        (clk),
        .rst_i            (rst),
        .isolate_req_i    (iso_req),
        .isolated_o       (iso),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .outstanding_wr_o (wr_cnt),
        .outstanding_rd_o (rd_cnt),
        .err_o            (err)
    );

    // in: {iso, aw_valid, aw_ready, b_valid, ar_valid, ar_ready, r_valid, r_last}
    // eo: {mst aw_valid, slv aw_ready, mst ar_valid, slv ar_ready} during the cycle
    typedef struct {
        logic [7:0] in;
        logic [3:0] eo;
        int         wr;
        int         rd;
        logic       iso;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [7:0] v);
        iso_req             = v[7];
        slv_req.aw_valid    = v[6];
        mst_resp.aw_ready   = v[5];
        mst_resp.b_valid    = v[4];
        slv_req.ar_valid    = v[3];
        mst_resp.ar_ready   = v[2];
        mst_resp.r_valid    = v[1];
        mst_resp.r.last     = v[0];
    endtask

    initial begin
        tbl[0]  = '{8'b0110_0000, 4'b1100, 1, 0, 1'b0};
        tbl[1]  = '{8'b0110_0000, 4'b1100, 2, 0, 1'b0};
        tbl[2]  = '{8'b0110_0000, 4'b1100, 3, 0, 1'b0};
        tbl[3]  = '{8'b0110_0000, 4'b0000, 3, 0, 1'b0};
        tbl[4]  = '{8'b0111_0000, 4'b0000, 2, 0, 1'b0};
        tbl[5]  = '{8'b0110_0000, 4'b1100, 3, 0, 1'b0};
        tbl[6]  = '{8'b1000_0000, 4'b0000, 3, 0, 1'b0};
        tbl[7]  = '{8'b1111_0000, 4'b0000, 2, 0, 1'b0};
        tbl[8]  = '{8'b1001_0000, 4'b0000, 1, 0, 1'b0};
        tbl[9]  = '{8'b1001_0000, 4'b0000, 0, 0, 1'b0};
        tbl[10] = '{8'b1000_0000, 4'b0000, 0, 0, 1'b1};
        tbl[11] = '{8'b1110_1100, 4'b0000, 0, 0, 1'b1};
        tbl[12] = '{8'b0000_1100, 4'b0000, 0, 0, 1'b0};
        tbl[13] = '{8'b0000_1100, 4'b0011, 0, 1, 1'b0};
        tbl[14] = '{8'b0000_1111, 4'b0011, 0, 1, 1'b0};
        tbl[15] = '{8'b0000_0010, 4'b0000, 0, 1, 1'b0};
        tbl[16] = '{8'b0000_0011, 4'b0000, 0, 0, 1'b0};
        tbl[17] = '{8'b0000_1100, 4'b0011, 0, 1, 1'b0};
        tbl[18] = '{8'b1000_0000, 4'b0000, 0, 1, 1'b0};
        tbl[19] = '{8'b0000_1100, 4'b0000, 0, 1, 1'b0};
        tbl[20] = '{8'b0000_1100, 4'b0011, 0, 2, 1'b0};
        tbl[21] = '{8'b0000_1100, 4'b0011, 0, 3, 1'b0};
        tbl[22] = '{8'b0000_1100, 4'b0000, 0, 3, 1'b0};
        tbl[23] = '{8'b0000_1111, 4'b0000, 0, 2, 1'b0};
        tbl[24] = '{8'b0000_1100, 4'b0011, 0, 3, 1'b0};
        tbl[25] = '{8'b0000_0011, 4'b0000, 0, 2, 1'b0};
        tbl[26] = '{8'b0000_0011, 4'b0000, 0, 1, 1'b0};
        tbl[27] = '{8'b0000_0011, 4'b0000, 0, 0, 1'b0};

        rst      = 1'b1;
        iso_req  = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        #3;
        chk("rst_iso", int'(iso), 0);
        chk("rst_wr", int'(wr_cnt), 0);
        chk("rst_rd", int'(rd_cnt), 0);
        chk("rst_err", int'(err), 0);
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 16'hA5C3;
        mst_resp.aw_ready = 1'b1;
        #1;
        chk("rst_aw_pass", int'(mst_req.aw_valid), 1);
        chk("aw_addr_pass", int'(mst_req.aw.addr), 16'hA5C3);
        chk("rst_awready_pass", int'(slv_resp.aw_ready), 1);
        slv_req  = '0;
        mst_resp = '0;
        #8 rst = 1'b0;
        cyc();

        // Idle isolate: request at cycle 0, isolated_o at cycle 2.
        iso_req = 1'b1;
        cyc();
        chk("idle_iso_c1", int'(iso), 0);
        cyc();
        chk("idle_iso_c2", int'(iso), 1);
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        slv_req.w_valid   = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b_valid  = 1'b1;
        #3;
        chk("iso_mst_awv", int'(mst_req.aw_valid), 0);
        chk("iso_slv_awr", int'(slv_resp.aw_ready), 0);
        chk("iso_mst_wv", int'(mst_req.w_valid), 0);
        chk("iso_slv_wr", int'(slv_resp.w_ready), 0);
        chk("iso_b_pass", int'(slv_resp.b_valid), 1);
        iso_req  = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        cyc();
        chk("release_iso", int'(iso), 0);

        // Traffic table with B/R always accepted upstream.
        slv_req.b_ready = 1'b1;
        slv_req.r_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].in);
            #3;
            chk($sformatf("v%0d_mawv", i), int'(mst_req.aw_valid),   int'(tbl[i].eo[3]));
            chk($sformatf("v%0d_sawr", i), int'(slv_resp.aw_ready),  int'(tbl[i].eo[2]));
            chk($sformatf("v%0d_marv", i), int'(mst_req.ar_valid),   int'(tbl[i].eo[1]));
            chk($sformatf("v%0d_sarr", i), int'(slv_resp.ar_ready),  int'(tbl[i].eo[0]));
            cyc();
            chk($sformatf("v%0d_wr", i),  int'(wr_cnt), tbl[i].wr);
            chk($sformatf("v%0d_rd", i),  int'(rd_cnt), tbl[i].rd);
            chk($sformatf("v%0d_iso", i), int'(iso),    int'(tbl[i].iso));
        end
        drv(8'h00);
        chk("tbl_err", int'(err), 0);

        // Valid stability: AW stalled downstream when isolate arrives.
        drv(8'b0100_0000);
        #3;
        chk("vs_awv0", int'(mst_req.aw_valid), 1);
        cyc();
        iso_req = 1'b1;
        #3;
        chk("vs_awv1", int'(mst_req.aw_valid), 1);
        cyc();
        #3;
        chk("vs_awv_drain", int'(mst_req.aw_valid), 1);
        chk("vs_awr_drain", int'(slv_resp.aw_ready), 0);
        cyc();
        chk("vs_iso0", int'(iso), 0);
        mst_resp.aw_ready = 1'b1;
        #3;
        chk("vs_awr_pass", int'(slv_resp.aw_ready), 1);
        cyc();
        chk("vs_wr1", int'(wr_cnt), 1);
        slv_req.aw_valid = 1'b1;
        #3;
        chk("vs_blk_after", int'(mst_req.aw_valid), 0);
        slv_req.aw_valid  = 1'b0;
        mst_resp.aw_ready = 1'b0;
        cyc();
        chk("vs_iso_wait", int'(iso), 0);
        mst_resp.b_valid = 1'b1;
        cyc();
        mst_resp.b_valid = 1'b0;
        chk("vs_wr0", int'(wr_cnt), 0);
        chk("vs_iso_b", int'(iso), 0);
        cyc();
        chk("vs_iso1", int'(iso), 1);
        iso_req = 1'b0;
        cyc();
        chk("vs_release", int'(iso), 0);

        // Error: B with nothing outstanding.
        drv(8'b0001_0000);
        cyc();
        drv(8'h00);
        chk("err_set", int'(err), 1);
        chk("err_wr0", int'(wr_cnt), 0);
        cyc();
        cyc();
        chk("err_sticky", int'(err), 1);

        // Asynchronous reset in the middle of a drain.
        drv(8'b0110_0000);
        cyc();
        drv(8'b1000_0000);
        cyc();
        chk("pre_rst_wr", int'(wr_cnt), 1);
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        #2;
        chk("pre_rst_blk", int'(mst_req.aw_valid), 0);
        rst = 1'b1;
        #1;
        chk("arst_wr", int'(wr_cnt), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_iso", int'(iso), 0);
        chk("arst_aw_pass", int'(mst_req.aw_valid), 1);
        iso_req  = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        #1 rst = 1'b0;
        cyc();
        cyc();
        chk("post_rst_iso", int'(iso), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
